// File: rtl/pulse_interval_pkg.sv
// Shared types and constants for the ZCD pulse-interval link.
// Preamble symbols are used by the encoder only when PULSE_PREAMBLE_EN is defined.
package pulse_interval_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      HIGH = 3'd2,
      LOW  = 3'd3,
      GAP  = 3'd4
   } state_t;

   localparam int DEF_ZERO_HI   = 2;
   localparam int DEF_ONE_HI    = 5;
   localparam int DEF_LOW_GAP   = 2;
   localparam int DEF_FRAME_GAP = 4;

   localparam logic [3:0] PREAMBLE = 4'b0101;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pulse_width_timer.sv
// Loadable down-counter shared by every timed phase of the encoder.
// Expire is high during the last cycle of a loaded interval (count == 1).
module pulse_width_timer #(
   parameter int CNT_W = 3
) (
   input  logic             sclk_3mhz,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge sclk_3mhz) begin
      if (!reset_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/pulse_interval_encode.sv
// Serialises words MSB-first as high pulses (short=0, long=1) each followed by a low gap.
// Define PULSE_PREAMBLE_EN to prefix every frame with the 0,1,0,1 preamble.
module pulse_interval_encode
   import pulse_interval_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ZERO_HI   = DEF_ZERO_HI,
   parameter int ONE_HI    = DEF_ONE_HI,
   parameter int LOW_GAP   = DEF_LOW_GAP,
   parameter int FRAME_GAP = DEF_FRAME_GAP
) (
   input  logic              sclk_3mhz,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              zcd_pulse_out,
   output logic              busy,
   output logic              frame_done
);

   localparam int TW  = $clog2(max3(ONE_HI, LOW_GAP, FRAME_GAP) + 1);
   localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_t            state;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] shift_nxt;
   logic [BCW-1:0]    bit_cnt;
   logic              accept;
   logic              tmr_load;
   logic [TW-1:0]     tmr_val;
   logic              tmr_expire;
`ifdef PULSE_PREAMBLE_EN
   logic [1:0]        pre_cnt;
   logic [1:0]        pre_idx;
   logic              pre_hi;
`endif

   function automatic logic [TW-1:0] hi_width(input logic b);
      return b ? TW'(ONE_HI) : TW'(ZERO_HI);
   endfunction

   assign accept    = data_valid && data_ready;
   assign shift_nxt = shift_reg << 1;
`ifdef PULSE_PREAMBLE_EN
   assign pre_idx   = pre_cnt - 2'd1;
`endif

   pulse_width_timer #(.CNT_W(TW)) u_timer (
      .sclk_3mhz (sclk_3mhz),
      .reset_n   (reset_n),
      .load      (tmr_load),
      .load_val  (tmr_val),
      .expire    (tmr_expire)
   );

   // Timer reload happens on the edge that leaves a phase, so each phase lasts exactly its width
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         IDLE: if (accept) begin
            tmr_load = 1'b1;
`ifdef PULSE_PREAMBLE_EN
            tmr_val  = hi_width(PREAMBLE[3]);
`else
            tmr_val  = hi_width(data_in[DATA_W-1]);
`endif
         end
`ifdef PULSE_PREAMBLE_EN
         PRE: if (tmr_expire) begin
            tmr_load = 1'b1;
            if (pre_hi)
               tmr_val = TW'(LOW_GAP);
            else if (pre_cnt == 2'd0)
               tmr_val = hi_width(shift_reg[DATA_W-1]);
            else
               tmr_val = hi_width(PREAMBLE[pre_idx]);
         end
`endif
         HIGH: if (tmr_expire) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(LOW_GAP);
         end
         LOW: if (tmr_expire) begin
            if (bit_cnt != '0) begin
               tmr_load = 1'b1;
               tmr_val  = hi_width(shift_nxt[DATA_W-1]);
            end else if (FRAME_GAP > 0) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(FRAME_GAP);
            end
         end
         default: ;
      endcase
   end

   // Outputs trail the state by one cycle, giving the one-edge accept-to-pulse latency
   always_ff @(posedge sclk_3mhz) begin
      if (!reset_n) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         zcd_pulse_out <= 1'b0;
         data_ready    <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
`ifdef PULSE_PREAMBLE_EN
         pre_cnt       <= 2'd0;
         pre_hi        <= 1'b0;
`endif
      end else begin
`ifdef PULSE_PREAMBLE_EN
         zcd_pulse_out <= (state == HIGH) || ((state == PRE) && pre_hi);
`else
         zcd_pulse_out <= (state == HIGH);
`endif
         busy          <= (state != IDLE) || accept;
         data_ready    <= (state == IDLE) && !accept;
         frame_done    <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               bit_cnt <= BCW'(DATA_W - 1);
`ifdef PULSE_PREAMBLE_EN
               state   <= PRE;
               pre_cnt <= 2'd3;
               pre_hi  <= 1'b1;
`else
               state   <= HIGH;
`endif
            end
`ifdef PULSE_PREAMBLE_EN
            PRE: if (tmr_expire) begin
               if (pre_hi) begin
                  pre_hi <= 1'b0;
               end else if (pre_cnt == 2'd0) begin
                  state  <= HIGH;
               end else begin
                  pre_cnt <= pre_idx;
                  pre_hi  <= 1'b1;
               end
            end
`endif
            HIGH: if (tmr_expire) state <= LOW;
            LOW: if (tmr_expire) begin
               if (bit_cnt != '0) begin
                  bit_cnt <= bit_cnt - 1'b1;
                  state   <= HIGH;
               end else if (FRAME_GAP > 0) begin
                  state <= GAP;
               end else begin
                  state      <= IDLE;
                  frame_done <= 1'b1;
               end
            end
            GAP: if (tmr_expire) begin
               state      <= IDLE;
               frame_done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge sclk_3mhz) begin
      if ((state == IDLE) && accept)
         shift_reg <= data_in;
      else if ((state == LOW) && tmr_expire && (bit_cnt != '0))
         shift_reg <= shift_nxt;
   end

endmodule

// File: tb/tb_pulse_interval_encode.sv
// Self-checking bench: frames are compared cycle by cycle against a pulse-list model.
// Honours PULSE_PREAMBLE_EN the same way the design does.
module tb_pulse_interval_encode;

   localparam int DATA_W    = 8;
   localparam int ZERO_HI   = 2;
   localparam int ONE_HI    = 5;
   localparam int LOW_GAP   = 2;
   localparam int FRAME_GAP = 4;
`ifdef PULSE_PREAMBLE_EN
   localparam int PRE_LEN   = 2*ZERO_HI + 2*ONE_HI + 4*LOW_GAP;
`else
   localparam int PRE_LEN   = 0;
`endif

   logic              sclk_3mhz  = 1'b0;
   logic              reset_n    = 1'b0;
   logic              data_valid = 1'b0;
   logic [DATA_W-1:0] data_in    = '0;
   logic              data_ready;
   logic              zcd_pulse_out;
   logic              busy;
   logic              frame_done;

   int n_chk = 0;
   int n_bad = 0;
   bit exp_q[$];

   always #5 sclk_3mhz = ~sclk_3mhz;

   pulse_interval_encode #(
      .DATA_W(DATA_W), .ZERO_HI(ZERO_HI), .ONE_HI(ONE_HI),
      .LOW_GAP(LOW_GAP), .FRAME_GAP(FRAME_GAP)
   ) dut (
      .sclk_3mhz     (sclk_3mhz),
      .reset_n       (reset_n),
      .data_in       (data_in),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .zcd_pulse_out (zcd_pulse_out),
      .busy          (busy),
      .frame_done    (frame_done)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge sclk_3mhz);
      #1;
   endtask

   task automatic push_pulse(input bit b);
      repeat (b ? ONE_HI : ZERO_HI) exp_q.push_back(1'b1);
      repeat (LOW_GAP) exp_q.push_back(1'b0);
   endtask

   // Expected line level for each cycle following the accept edge
   task automatic build_frame(input logic [DATA_W-1:0] w);
      logic [3:0] pre;
      pre = 4'b0101;
      exp_q.delete();
`ifdef PULSE_PREAMBLE_EN
      for (int i = 3; i >= 0; i--) push_pulse(pre[i]);
`else
      if (pre[0]) exp_q.delete();
`endif
      for (int i = DATA_W-1; i >= 0; i--) push_pulse(w[i]);
      repeat (FRAME_GAP) exp_q.push_back(1'b0);
   endtask

   task automatic wait_ready(output int waited);
      waited = 0;
      while (!data_ready && waited < 200) begin
         tick;
         waited++;
      end
      check_val("ready_before_accept", data_ready, 1);
   endtask

   task automatic send_word(input logic [DATA_W-1:0] w, input bit hold_valid,
                            input bit poke_mid, output int waited, output int done_t);
      build_frame(w);
      data_in    = w;
      data_valid = 1'b1;
      wait_ready(waited);
      tick;
      if (!hold_valid) data_valid = 1'b0;
      check_val("out_at_accept", zcd_pulse_out, 0);
      check_val("ready_after_accept", data_ready, 0);
      check_val("busy_after_accept", busy, 1);
      done_t = -1;
      for (int t = 1; t <= exp_q.size(); t++) begin
         if (poke_mid && t == 10) begin
            data_valid = 1'b1;
            data_in    = 8'h3C;
         end
         if (poke_mid && t == 11) data_valid = 1'b0;
         tick;
         check_val($sformatf("out_w%02h_t%0d", w, t), zcd_pulse_out, int'(exp_q[t-1]));
         check_val($sformatf("done_w%02h_t%0d", w, t), frame_done, int'(t == exp_q.size()));
         check_val("ready_in_frame", data_ready, 0);
         check_val("busy_in_frame", busy, 1);
         if (frame_done && done_t < 0) done_t = t;
      end
      tick;
      check_val("ready_after_frame", data_ready, 1);
      check_val("busy_after_frame", busy, 0);
      check_val("done_after_frame", frame_done, 0);
      check_val("out_after_frame", zcd_pulse_out, 0);
   endtask

   task automatic send_abort(input logic [DATA_W-1:0] w);
      int waited;
      int pulses;
      int t;
      bit prev;
      build_frame(w);
      data_in    = w;
      data_valid = 1'b1;
      wait_ready(waited);
      tick;
      data_valid = 1'b0;
      pulses = 0;
      prev   = 1'b0;
      t      = 0;
      while (pulses < 3 && t < exp_q.size()) begin
         tick;
         t++;
         if (exp_q[t-1] && !prev) pulses++;
         prev = exp_q[t-1];
      end
      check_val("abort_pulse3_high", zcd_pulse_out, 1);
      reset_n = 1'b0;
      tick;
      check_val("abort_out", zcd_pulse_out, 0);
      check_val("abort_done", frame_done, 0);
      check_val("abort_busy", busy, 0);
      check_val("abort_ready", data_ready, 0);
      tick;
      reset_n = 1'b1;
      for (int i = 0; i < exp_q.size() + 4; i++) begin
         tick;
         check_val("abort_no_done", frame_done, 0);
         check_val("abort_line_quiet", zcd_pulse_out, 0);
      end
      check_val("abort_ready_back", data_ready, 1);
   endtask

   initial begin
      int  waited;
      int  done_t;
      bit  held;
      logic [DATA_W-1:0] w;

      // Reset with data_valid already pending
      reset_n    = 1'b0;
      data_valid = 1'b1;
      data_in    = 8'hA5;
      repeat (3) begin
         tick;
         check_val("rst_out", zcd_pulse_out, 0);
         check_val("rst_ready", data_ready, 0);
         check_val("rst_busy", busy, 0);
         check_val("rst_done", frame_done, 0);
      end
      reset_n = 1'b1;
      tick;
      check_val("ready_first_after_reset", data_ready, 1);

      send_word(8'hA5, 1'b0, 1'b0, waited, done_t);
      check_val("a5_accept_next_edge", waited, 0);
      check_val("a5_done_cycle", done_t, 48 + PRE_LEN);

      // Back-to-back 00 then FF with valid held
      send_word(8'h00, 1'b1, 1'b0, waited, done_t);
      check_val("zero_done_cycle", done_t, 8*ZERO_HI + 8*LOW_GAP + FRAME_GAP + PRE_LEN);
      send_word(8'hFF, 1'b0, 1'b0, waited, done_t);
      check_val("b2b_second_accept", waited, 0);
      check_val("ff_done_cycle", done_t, 8*ONE_HI + 8*LOW_GAP + FRAME_GAP + PRE_LEN);

      // Mid-frame valid pulse must be ignored
      repeat (2) tick;
      send_word(8'hA5, 1'b0, 1'b1, waited, done_t);
      check_val("poke_done_cycle", done_t, 48 + PRE_LEN);

      send_abort(8'hA5);
      send_word(8'hA5, 1'b0, 1'b0, waited, done_t);
      check_val("after_abort_done", done_t, 48 + PRE_LEN);

      send_word(8'h80, 1'b0, 1'b0, waited, done_t);

      held = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (!held) repeat ($urandom_range(0, 3)) tick;
         w    = DATA_W'($urandom);
         held = ($urandom_range(0, 1) == 1);
         send_word(w, held, ($urandom_range(0, 3) == 0) && !held, waited, done_t);
         if (held) check_val("rand_b2b_gap", waited, 0);
      end
      data_valid = 1'b0;
      repeat (2) tick;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
